// File: rtl/line_cache_n.sv
// line_cache_n: frame-RAM row cache feeding the filter accelerator.
// Ports: clk/rst_n; mem_* RAM port; en/we/di/start requests; rows_cached/out_valid/dout column.
module line_cache_n #(
  parameter int WIDTH     = 352,
  parameter int HEIGHT    = 288,
  parameter int ROWS      = 3,
  parameter int RD_BASE   = 0,
  parameter int WR_BASE   = WIDTH*HEIGHT/4,
  parameter int BYTE_SWAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [15:0]       mem_addr,
  input  logic [31:0]       mem_do,
  output logic [31:0]       mem_di,
  output logic              mem_en,
  output logic              mem_we,
  input  logic              en,
  input  logic              we,
  input  logic [31:0]       di,
  input  logic              start,
  output logic              rows_cached,
  output logic              out_valid,
  output logic [32*ROWS-1:0] dout
);

  localparam int ROW_WORDS = WIDTH/4;
  localparam int FRAME_WORDS = WIDTH*HEIGHT/4;
  localparam int CW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam int RW = $clog2(ROWS);
  localparam logic [15:0] LAST = 16'(FRAME_WORDS-1);
  localparam logic [CW-1:0] CLAST = CW'(ROW_WORDS-1);
  localparam logic [RW-1:0] RLAST = RW'(ROWS-1);

  function automatic logic [31:0] swap(input logic [31:0] x);
    if (BYTE_SWAP != 0)
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
    return x;
  endfunction

  function automatic logic [15:0] inc(input logic [15:0] p);
    return (p == LAST) ? 16'd0 : p + 16'd1;
  endfunction

  logic              rq_en_q, rq_en_d;
  logic              rq_we_q, rq_we_d;
  logic [31:0]       rq_di_q, rq_di_d;
  logic              men_q, men_d;
  logic              mwe_q, mwe_d;
  logic [15:0]       maddr_q, maddr_d;
  logic [31:0]       mdi_q, mdi_d;
  logic              t1_q, t1_d;
  logic              t2_q, t2_d;
  logic [15:0]       rd_ptr_q, rd_ptr_d;
  logic [15:0]       wr_ptr_q, wr_ptr_d;
  logic [15:0]       idx_q, idx_d;
  logic [CW-1:0]     c_q, c_d;
  logic [RW-1:0]     r_q, r_d;
  logic              cached_q, cached_d;
  logic              vld_q, vld_d;
  logic [32*ROWS-1:0] dout_q, dout_d;
  logic              cap;
  logic [31:0]       word;
  logic [31:0]       lb_q [ROWS-1][ROW_WORDS];

  always_comb begin
    rq_en_d  = en & ~start;
    rq_we_d  = we;
    rq_di_d  = di;
    men_d    = rq_en_q;
    mwe_d    = rq_en_q & rq_we_q;
    maddr_d  = maddr_q;
    mdi_d    = mdi_q;
    // t1/t2 tag a read through the RAM round trip
    t1_d     = rq_en_q & ~rq_we_q & ~start;
    t2_d     = t1_q & ~start;
    cap      = t2_q & ~start;
    word     = swap(mem_do);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    idx_d    = idx_q;
    c_d      = c_q;
    r_d      = r_q;
    cached_d = cached_q;
    vld_d    = cap;
    dout_d   = dout_q;
    if (rq_en_q & rq_we_q) begin
      maddr_d  = 16'(WR_BASE) + wr_ptr_q;
      mdi_d    = swap(rq_di_q);
      wr_ptr_d = inc(wr_ptr_q);
    end else if (rq_en_q) begin
      maddr_d  = 16'(RD_BASE) + rd_ptr_q;
      rd_ptr_d = inc(rd_ptr_q);
    end
    if (cap) begin
      dout_d[31:0] = word;
      // rows above the current frame's first row are hidden
      for (int k = 1; k < ROWS; k++) begin
        if (int'(r_q) >= k)
          dout_d[32*k +: 32] = lb_q[k-1][c_q];
        else
          dout_d[32*k +: 32] = '0;
      end
      cached_d = (r_q == RLAST);
      if (idx_q == LAST) begin
        idx_d = '0;
        c_d   = '0;
        r_d   = '0;
      end else begin
        idx_d = idx_q + 16'd1;
        if (c_q == CLAST) begin
          c_d = '0;
          if (r_q != RLAST)
            r_d = r_q + RW'(1);
        end else begin
          c_d = c_q + CW'(1);
        end
      end
    end
    if (start) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      idx_d    = '0;
      c_d      = '0;
      r_d      = '0;
      cached_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_en_q  <= 1'b0;
      rq_we_q  <= 1'b0;
      rq_di_q  <= '0;
      men_q    <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mdi_q    <= '0;
      t1_q     <= 1'b0;
      t2_q     <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      idx_q    <= '0;
      c_q      <= '0;
      r_q      <= '0;
      cached_q <= 1'b0;
      vld_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      rq_en_q  <= rq_en_d;
      rq_we_q  <= rq_we_d;
      rq_di_q  <= rq_di_d;
      men_q    <= men_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mdi_q    <= mdi_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      idx_q    <= idx_d;
      c_q      <= c_d;
      r_q      <= r_d;
      cached_q <= cached_d;
      vld_q    <= vld_d;
      dout_q   <= dout_d;
    end
  end

  // line buffers are never cleared; slot masking hides stale rows
  always_ff @(posedge clk) begin
    if (cap) begin
      lb_q[0][c_q] <= word;
      for (int k = 1; k < ROWS-1; k++)
        lb_q[k][c_q] <= lb_q[k-1][c_q];
    end
  end

  assign mem_en      = men_q;
  assign mem_we      = mwe_q;
  assign mem_addr    = maddr_q;
  assign mem_di      = mdi_q;
  assign out_valid   = vld_q;
  assign rows_cached = cached_q;
  assign dout        = dout_q;

endmodule

// File: tb/tb_line_cache_n.sv
// tb_line_cache_n: table-driven bench for line_cache_n.
// 16x4 frame, 3 rows, read base 32, byte swap on.
module tb_line_cache_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_addr;
  logic [31:0] mem_do;
  logic [31:0] mem_di;
  logic        mem_en, mem_we;
  logic        en, we, start;
  logic [31:0] di;
  logic        rows_cached, out_valid;
  logic [95:0] dout;

  line_cache_n #(
    .WIDTH(16), .HEIGHT(4), .ROWS(3),
    .RD_BASE(32), .BYTE_SWAP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_do(mem_do),
    .mem_di(mem_di), .mem_en(mem_en),
    .mem_we(mem_we), .en(en), .we(we),
    .di(di), .start(start),
    .rows_cached(rows_cached),
    .out_valid(out_valid), .dout(dout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ram [64];
  always @(posedge clk)
    if (mem_en && !mem_we) mem_do <= ram[mem_addr[5:0]];

  typedef struct {
    logic [95:0] d;
    logic        c;
    int          t;
  } col_t;
  col_t        col_q[$];
  logic [15:0] addr_q[$];
  int          iss_q[$];

  always @(negedge clk) begin
    if (mem_en && !mem_we) addr_q.push_back(mem_addr);
    if (out_valid) col_q.push_back('{dout, rows_cached, cyc});
  end

  typedef struct {
    logic [15:0] a;
    logic [31:0] s0, s1, s2;
    logic        c;
  } vec_t;
  vec_t tbl[17];

  function automatic vec_t mk(int a, int s0, int s1, int s2, int c);
    vec_t v;
    v.a = 16'(a);
    v.s0 = 32'(s0);
    v.s1 = 32'(s1);
    v.s2 = 32'(s2);
    v.c = (c != 0);
    return v;
  endfunction

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic chk(input string nm, input logic [95:0] a,
                     input logic [95:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic clrq();
    col_q.delete();
    addr_q.delete();
    iss_q.delete();
  endtask

  task automatic rd(input int gap);
    @(negedge clk);
    en = 1'b1;
    we = 1'b0;
    iss_q.push_back(cyc + 1);
    if (gap > 0) begin
      @(negedge clk);
      en = 1'b0;
      repeat (gap-1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    en = 1'b0;
    we = 1'b0;
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_tbl(input string tg);
    chk({tg, "_ncol"}, 96'(col_q.size()), 96'(17));
    chk({tg, "_naddr"}, 96'(addr_q.size()), 96'(17));
    for (int i = 0; i < 17; i++) begin
      if (i < addr_q.size())
        chk($sformatf("%s_addr%0d", tg, i),
            96'(addr_q[i]), 96'(tbl[i].a));
      if (i < col_q.size()) begin
        chk($sformatf("%s_dout%0d", tg, i), col_q[i].d,
            {tbl[i].s2, tbl[i].s1, tbl[i].s0});
        chk($sformatf("%s_cach%0d", tg, i),
            96'(col_q[i].c), 96'(tbl[i].c));
        if (i < iss_q.size())
          chk($sformatf("%s_lat%0d", tg, i),
              96'(col_q[i].t - iss_q[i]), 96'(3));
      end
    end
  endtask

  initial begin
    en = 1'b0;
    we = 1'b0;
    di = '0;
    start = 1'b0;
    for (int i = 0; i < 64; i++) ram[i] = '0;
    for (int i = 0; i < 16; i++) ram[32+i] = bsw(32'(i));

    tbl[0]  = mk(32,  0,  0, 0, 0);
    tbl[1]  = mk(33,  1,  0, 0, 0);
    tbl[2]  = mk(34,  2,  0, 0, 0);
    tbl[3]  = mk(35,  3,  0, 0, 0);
    tbl[4]  = mk(36,  4,  0, 0, 0);
    tbl[5]  = mk(37,  5,  1, 0, 0);
    tbl[6]  = mk(38,  6,  2, 0, 0);
    tbl[7]  = mk(39,  7,  3, 0, 0);
    tbl[8]  = mk(40,  8,  4, 0, 1);
    tbl[9]  = mk(41,  9,  5, 1, 1);
    tbl[10] = mk(42, 10,  6, 2, 1);
    tbl[11] = mk(43, 11,  7, 3, 1);
    tbl[12] = mk(44, 12,  8, 4, 1);
    tbl[13] = mk(45, 13,  9, 5, 1);
    tbl[14] = mk(46, 14, 10, 6, 1);
    tbl[15] = mk(47, 15, 11, 7, 1);
    tbl[16] = mk(32,  0,  0, 0, 0);

    repeat (2) @(negedge clk);
    chk("rst_valid", 96'(out_valid), 96'(0));
    chk("rst_en", 96'(mem_en), 96'(0));
    chk("rst_we", 96'(mem_we), 96'(0));
    chk("rst_addr", 96'(mem_addr), 96'(0));
    chk("rst_di", 96'(mem_di), 96'(0));
    chk("rst_cach", 96'(rows_cached), 96'(0));
    chk("rst_dout", dout, 96'(0));
    rst_n = 1'b1;
    clrq();

    // fill, rows_cached rise and frame wrap
    for (int i = 0; i < 17; i++) rd(0);
    idle(8);
    run_tbl("b2b");

    // async reset with reads in flight
    clrq();
    rd(0);
    rd(0);
    rd(0);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_vld", 96'(out_valid), 96'(1));
    chk("pre_rst_dout", dout, 96'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 96'(out_valid), 96'(0));
    chk("mid_rst_dout", dout, 96'(0));
    chk("mid_rst_en", 96'(mem_en), 96'(0));
    chk("mid_rst_addr", 96'(mem_addr), 96'(0));
    clrq();
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    chk("rst_abort", 96'(col_q.size()), 96'(0));
    clrq();
    rd(0);
    idle(6);
    chk("rel_n", 96'(col_q.size()), 96'(1));
    if (addr_q.size() > 0)
      chk("rel_addr", 96'(addr_q[0]), 96'(32));
    if (col_q.size() > 0)
      chk("rel_dout", col_q[0].d, 96'(0));

    // same frame with request gaps after a restart
    pulse_start();
    clrq();
    for (int i = 0; i < 17; i++) rd(i % 3);
    idle(8);
    run_tbl("gap");

    // request sampled together with start is dropped
    clrq();
    @(negedge clk);
    en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    en = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("drop_en", 96'(mem_en), 96'(0));
    idle(5);
    chk("drop_naddr", 96'(addr_q.size()), 96'(0));
    chk("drop_ncol", 96'(col_q.size()), 96'(0));

    // start while a read is in flight
    clrq();
    rd(0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(5);
    chk("infl_ncol", 96'(col_q.size()), 96'(0));
    clrq();
    rd(0);
    idle(6);
    chk("infl_n", 96'(col_q.size()), 96'(1));
    if (addr_q.size() > 0)
      chk("infl_addr", 96'(addr_q[0]), 96'(32));

    // byte order on read and write paths
    ram[32] = 32'h11223344;
    pulse_start();
    clrq();
    rd(0);
    idle(6);
    chk("swap_n", 96'(col_q.size()), 96'(1));
    if (col_q.size() > 0)
      chk("swap_rd", col_q[0].d, {64'h0, 32'h44332211});
    @(negedge clk);
    en = 1'b1;
    we = 1'b1;
    di = 32'hAABBCCDD;
    @(negedge clk);
    di = 32'h01020304;
    @(negedge clk);
    en = 1'b0;
    we = 1'b0;
    chk("wr0_en", 96'(mem_en), 96'(1));
    chk("wr0_we", 96'(mem_we), 96'(1));
    chk("wr0_addr", 96'(mem_addr), 96'(16));
    chk("wr0_di", 96'(mem_di), 96'(32'hDDCCBBAA));
    @(negedge clk);
    chk("wr1_addr", 96'(mem_addr), 96'(17));
    chk("wr1_di", 96'(mem_di), 96'(32'h04030201));
    @(negedge clk);
    chk("wr_idle_en", 96'(mem_en), 96'(0));
    chk("wr_idle_we", 96'(mem_we), 96'(0));
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
